// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants for the MIPS-style front end.
package mips_pkg;

    localparam int unsigned INST_BYTES = 4;
    localparam int unsigned PC_W       = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_VALID
    } fetch_state_t;

    typedef enum logic [1:0] {
        NPC_SEQ,
        NPC_BR,
        NPC_J,
        NPC_JR
    } npc_sel_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/acknowledge bus between the fetch sequencer and imem.
interface fetch_sequencer_if;
    import mips_pkg::*;

    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jr > jump > taken branch > sequential.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [PC_W-1:0] i_pc,
    input  logic            i_jump,
    input  logic            i_branch,
    input  logic            i_zero,
    input  logic            i_jr,
    input  logic [25:0]     i_target_inst,
    input  logic [31:0]     i_se_in,
    input  logic [31:0]     i_reg_da,
    output logic [PC_W-1:0] o_npc,
    output npc_sel_t        o_npc_sel
);

    logic [PC_W-1:0] w_pc4;

    assign w_pc4 = i_pc + PC_W'(INST_BYTES);

    always_comb begin
        o_npc_sel = NPC_SEQ;
        o_npc     = w_pc4;
        if (i_jr) begin
            o_npc_sel = NPC_JR;
            o_npc     = i_reg_da & ~32'h3;
        end else if (i_jump) begin
            o_npc_sel = NPC_J;
            o_npc     = {w_pc4[31:28], i_target_inst, 2'b00};
        end else if (i_branch && i_zero) begin
            o_npc_sel = NPC_BR;
            o_npc     = w_pc4 + (i_se_in << 2);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, issues one imem fetch at a time, holds it until retire.
// Optional FETCH_TIMEOUT_EN builds a sticky fetch_err watchdog on ackless request cycles.
module fetch_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    fetch_sequencer_if.master   bus,
    output logic                inst_valid,
    output logic [31:0]         inst,
    output logic [31:0]         inst_pc,
    input  logic                stall,
    input  logic                jump,
    input  logic                branch,
    input  logic                zero,
    input  logic                jr,
    input  logic [25:0]         target_inst,
    input  logic [31:0]         se_in,
    input  logic [31:0]         reg_da,
    output logic [31:0]         retire_cnt,
    output logic                fetch_err
);

    fetch_state_t    r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_req;
    logic            r_valid;
    logic [31:0]     r_inst;
    logic [31:0]     r_inst_pc;
    logic [31:0]     r_retire_cnt;

    logic [PC_W-1:0] w_npc;
    npc_sel_t        w_npc_sel;
    logic            w_retire;

    assign w_retire = (r_state == S_VALID) && !stall;

    next_pc_calc u_next_pc_calc (
        .i_pc          (r_pc),
        .i_jump        (jump),
        .i_branch      (branch),
        .i_zero        (zero),
        .i_jr          (jr),
        .i_target_inst (target_inst),
        .i_se_in       (se_in),
        .i_reg_da      (reg_da),
        .o_npc         (w_npc),
        .o_npc_sel     (w_npc_sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_req        <= 1'b0;
            r_valid      <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_retire_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    r_req   <= 1'b1;
                end
                S_REQ: begin
                    if (bus.imem_ack) begin
                        r_inst    <= bus.imem_rdata;
                        r_inst_pc <= r_pc;
                        r_valid   <= 1'b1;
                        r_req     <= 1'b0;
                        r_state   <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (!stall) begin
                        r_pc         <= w_npc;
                        r_retire_cnt <= r_retire_cnt + 32'd1;
                        r_valid      <= 1'b0;
                        r_req        <= 1'b1;
                        r_state      <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_fetch_err;

    // Counter saturates at TIMEOUT; the request itself is never aborted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt    <= '0;
            r_fetch_err <= 1'b0;
        end else if ((r_state == S_IDLE) || w_retire) begin
            r_to_cnt <= '0;
        end else if ((r_state == S_REQ) && !bus.imem_ack && (r_to_cnt != TO_W'(TIMEOUT))) begin
            r_to_cnt <= r_to_cnt + 1'b1;
            if (r_to_cnt == TO_W'(TIMEOUT - 1))
                r_fetch_err <= 1'b1;
        end
    end

    assign fetch_err = r_fetch_err;
`else
    assign fetch_err = 1'b0;
`endif

    assign bus.imem_req  = r_req;
    assign bus.imem_addr = r_pc;
    assign inst_valid    = r_valid;
    assign inst          = r_inst;
    assign inst_pc       = r_inst_pc;
    assign retire_cnt    = r_retire_cnt;

    a_jr_priority : assert property (@(posedge clk) disable iff (rst)
        ((r_state == S_VALID) && jr) |-> (w_npc_sel == NPC_JR));

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller that owns the program counter and sequences it against a request/acknowledge instruction memory.
- Issues one fetch at a time and holds the fetched instruction until the datapath consumes it.
- On consumption, computes the next PC from the datapath's jump/branch/zero/jr controls.
- Sits between the PC/next-PC logic and imem; the decode stage reads inst/inst_pc.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded by reset
TIMEOUT, 16, cycles without imem_ack before fetch_err (used only with FETCH_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  32  fetch address (current PC), stable while imem_req=1
imem_ack  in  1  imem data valid this cycle
imem_rdata  in  32  instruction word, sampled when imem_req&imem_ack
inst_valid  out  1  inst/inst_pc hold a fetched, unconsumed instruction
inst  out  32  fetched instruction
inst_pc  out  32  address of inst
stall  in  1  datapath not ready; instruction retires when inst_valid & ~stall
jump  in  1  j/jal taken (sampled at retire)
branch  in  1  conditional branch instruction (sampled at retire)
zero  in  1  ALU zero flag (sampled at retire)
jr  in  1  register jump (sampled at retire)
target_inst  in  26  jump target field
se_in  in  32  sign-extended branch offset, in words
reg_da  in  32  register operand for jr
retire_cnt  out  32  retired-instruction count
fetch_err  out  1  sticky fetch timeout flag (tied 0 without FETCH_TIMEOUT_EN)

Behaviour:
- Reset, any state, including mid-fetch:
  - state=S_IDLE, pc=RESET_PC.
  - imem_req=0, inst_valid=0, inst=0, inst_pc=0, retire_cnt=0, fetch_err=0.
  - An outstanding request is abandoned; an ack arriving in the reset cycle is ignored.
- S_IDLE: one cycle after rst deasserts, then go to S_REQ.
- S_REQ:
  - Drive imem_req=1 and imem_addr=pc.
  - Same-cycle ack is legal. On imem_ack, at the next edge: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, go to S_VALID.
  - Without ack, stay in S_REQ with addr unchanged.
- S_VALID:
  - imem_req=0; inst_valid=1.
  - stall=1: hold all outputs.
  - stall=0 (retire): pc<=npc, retire_cnt<=retire_cnt+1 (wraps at 2^32), inst_valid<=0, go to S_REQ.
- imem_ack outside S_REQ: ignored.
- npc, priority jr > jump > branch&zero > sequential, with pc4=pc+4:
  - jr: {reg_da[31:2],2'b00}
  - jump: {pc4[31:28],target_inst,2'b00}
  - branch&zero: pc4+(se_in<<2)
  - else: pc4
- All adds are modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- branch=1 with zero=0 takes the sequential path.
- Control inputs are ignored except in the retire cycle.
- Throughput: 2 cycles per instruction minimum (ack in the first S_REQ cycle, stall=0 in S_VALID).

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A counter clears on entry to S_REQ and increments each S_REQ cycle without ack.
  - When it reaches TIMEOUT, fetch_err<=1 (sticky until rst). The fetch continues; a later ack is still accepted.
- Undefined: no counter is built; fetch_err is constant 0.

Decomposition:
- Shared package mips_pkg holds:
  - fetch_state_t enum {S_IDLE,S_REQ,S_VALID}
  - npc_sel_t enum {NPC_SEQ,NPC_BR,NPC_J,NPC_JR}
  - constants INST_BYTES=4 and PC_W=32
- Sub-module next_pc_calc: purely combinational; inputs pc, controls, target_inst, se_in, reg_da; outputs npc and npc_sel.
- fetch_sequencer owns the FSM, registers and counters.

Test Plan:
- Reset then immediate acks, stall=0, RESET_PC=0 -> imem_addr sequence 0,4,8,C; inst_valid one cycle per 2; retire_cnt=4 after 4 retires.
- Ack delayed 3 cycles -> imem_req high 4 cycles with imem_addr stable at 8; inst=imem_rdata from the ack cycle; stall=1 for 5 cycles holds inst/inst_pc constant.
- Retires at pc=0x40, each with the sequential retire between them:
  - branch=1, zero=1, se_in=32'hFFFF_FFFE -> next imem_addr=0x3C.
  - branch=1, zero=0 -> 0x44.
  - jump=1, target_inst=26'h000_0100 at pc=0x1000_0040 -> 0x1000_0400.
  - jr=1, jump=1, reg_da=0x0000_2003 -> 0x0000_2000 (jr wins, low bits cleared).
- pc=32'hFFFF_FFFC, sequential retire -> next imem_addr=0; rst asserted while imem_req=1 -> next cycle imem_req=0, inst_valid=0, pc=RESET_PC.
- With FETCH_TIMEOUT_EN, TIMEOUT=16, ack withheld 20 cycles -> fetch_err rises after 16 ackless cycles and stays 1 after the ack and retire, until rst. Without the macro, the same stimulus -> fetch_err=0.
